// File: rtl/cic_interp.sv
// cic_interp: Q-stage CIC interpolator, runtime R in {1,2,4,8,16}, Q1.15 I/O.
// Define CIC_INTERP_SAT_EN for output saturation and overflow/underflow flags.
module cic_interp #(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_FRAC  = 15,
    parameter int Q          = 1,
    parameter int N          = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  logic [4:0]            interp_factor,
    input  logic [DATA_WIDTH-1:0] cic_in,
    output logic [DATA_WIDTH-1:0] cic_out,
    output logic                  valid_out,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int MAX_INTERP_FACTOR = 16;
    localparam int ACC_WIDTH = DATA_WIDTH + Q * $clog2(N * MAX_INTERP_FACTOR);
    localparam int LOG2N     = $clog2(N);
    localparam int SW        = $clog2(ACC_WIDTH + 1);
    // sign bit index: fractional bits plus integer bits below the sign
    localparam int MAG_BITS  = DATA_FRAC + (DATA_WIDTH - 1 - DATA_FRAC);
    localparam logic signed [ACC_WIDTH:0] ONE = 1;
`ifdef CIC_INTERP_SAT_EN
    localparam logic signed [ACC_WIDTH:0] SAT_HI =
        {{(ACC_WIDTH + 2 - DATA_WIDTH){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_LO =
        {{(ACC_WIDTH + 2 - DATA_WIDTH){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
`endif

    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    logic                  busy_q, busy_d;
    logic [4:0]            phase_q, phase_d;
    logic [4:0]            r_q, r_d;
    logic [2:0]            lg_q, lg_d;
    acc_t                  stuff_q, stuff_d;
    acc_t                  dly_q [Q][N];
    acc_t                  dly_d [Q][N];
    acc_t                  integ_q [Q];
    acc_t                  integ_d [Q];
    logic                  ivld_q, ivld_d;
    logic [SW-1:0]         shift_q, shift_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  vout_q, vout_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic                  rdy;
    logic                  last_phase;
    logic                  accept;
    logic [4:0]            r_dec;
    logic [2:0]            lg_dec;
    acc_t                  comb_x [Q+1];
    acc_t                  integ_in;
    logic signed [ACC_WIDTH:0] rnd_add;
    logic signed [ACC_WIDTH:0] rnd;
    logic [DATA_WIDTH-1:0] res;
    logic                  res_ovf;
    logic                  res_unf;
`ifdef CIC_INTERP_SAT_EN
    logic signed [ACC_WIDTH:0] scaled;
`endif

    // Burst control: accept, R latch, phase counter, comb chain and delays
    always_comb begin
        last_phase = busy_q && (phase_q == r_q - 5'd1);
        rdy        = !busy_q || last_phase;
        accept     = valid_in && rdy;

        r_dec  = 5'd1;
        lg_dec = 3'd0;
        unique case (1'b1)
            (interp_factor == 5'd2):  begin r_dec = 5'd2;  lg_dec = 3'd1; end
            (interp_factor == 5'd4):  begin r_dec = 5'd4;  lg_dec = 3'd2; end
            (interp_factor == 5'd8):  begin r_dec = 5'd8;  lg_dec = 3'd3; end
            (interp_factor == 5'd16): begin r_dec = 5'd16; lg_dec = 3'd4; end
            default: ;
        endcase

        comb_x[0] = {{(ACC_WIDTH - MAG_BITS){cic_in[MAG_BITS]}},
                     cic_in[MAG_BITS-1:0]};
        for (int k = 0; k < Q; k++) begin
            comb_x[k+1] = comb_x[k] - dly_q[k][N-1];
        end

        busy_d  = busy_q;
        phase_d = phase_q;
        r_d     = r_q;
        lg_d    = lg_q;
        stuff_d = stuff_q;
        dly_d   = dly_q;
        if (accept) begin
            busy_d  = 1'b1;
            phase_d = 5'd0;
            r_d     = r_dec;
            lg_d    = lg_dec;
            stuff_d = comb_x[Q];
            for (int k = 0; k < Q; k++) begin
                dly_d[k][0] = comb_x[k];
                for (int j = 1; j < N; j++) begin
                    dly_d[k][j] = dly_q[k][j-1];
                end
            end
        end else if (last_phase) begin
            busy_d  = 1'b0;
            phase_d = 5'd0;
        end else if (busy_q) begin
            phase_d = phase_q + 5'd1;
        end
    end

    // Integrator cascade: zero-stuffed input, runs only during a burst
    always_comb begin
        integ_in = (phase_q == 5'd0) ? stuff_q : '0;
        integ_d  = integ_q;
        ivld_d   = busy_q;
        shift_d  = shift_q;
        if (busy_q) begin
            integ_d[0] = integ_q[0] + integ_in;
            for (int k = 1; k < Q; k++) begin
                integ_d[k] = integ_q[k] + integ_d[k-1];
            end
            shift_d = SW'((Q - 1) * int'(lg_q) + Q * LOG2N);
        end
    end

    // Gain removal: half-up rounding, shift, then clamp or wrap
    always_comb begin
        rnd_add = '0;
        if (shift_q != '0) begin
            rnd_add = ONE << (shift_q - SW'(1));
        end
        rnd = {integ_q[Q-1][ACC_WIDTH-1], integ_q[Q-1]} + rnd_add;
`ifdef CIC_INTERP_SAT_EN
        scaled  = rnd >>> shift_q;
        res     = scaled[DATA_WIDTH-1:0];
        res_ovf = 1'b0;
        res_unf = 1'b0;
        if (scaled > SAT_HI) begin
            res     = SAT_HI[DATA_WIDTH-1:0];
            res_ovf = 1'b1;
        end else if (scaled < SAT_LO) begin
            res     = SAT_LO[DATA_WIDTH-1:0];
            res_unf = 1'b1;
        end
`else
        res     = DATA_WIDTH'(rnd >>> shift_q);
        res_ovf = 1'b0;
        res_unf = 1'b0;
`endif
        out_d  = out_q;
        vout_d = 1'b0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        if (ivld_q) begin
            out_d  = res;
            vout_d = 1'b1;
            ovf_d  = res_ovf;
            unf_d  = res_unf;
        end
    end

    // State registers; reset abandons any burst in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            phase_q <= '0;
            r_q     <= 5'd1;
            lg_q    <= '0;
            stuff_q <= '0;
            for (int k = 0; k < Q; k++) begin
                integ_q[k] <= '0;
                for (int j = 0; j < N; j++) begin
                    dly_q[k][j] <= '0;
                end
            end
            ivld_q  <= 1'b0;
            shift_q <= '0;
            out_q   <= '0;
            vout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            phase_q <= phase_d;
            r_q     <= r_d;
            lg_q    <= lg_d;
            stuff_q <= stuff_d;
            integ_q <= integ_d;
            dly_q   <= dly_d;
            ivld_q  <= ivld_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            vout_q  <= vout_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign ready_in  = rdy;
    assign cic_out   = out_q;
    assign valid_out = vout_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_cic_interp.sv
// tb_cic_interp: directed scoreboard bench for cic_interp.
// Two instances: Q=1 (u_q1) and Q=2 (u_q2), both N=1.
module tb_cic_interp;

    localparam int DW = 16;
`ifdef CIC_INTERP_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] d;
        logic          ov;
        logic          un;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          v1 = 1'b0;
    logic          v2 = 1'b0;
    logic [4:0]    f1 = 5'd1;
    logic [4:0]    f2 = 5'd1;
    logic [DW-1:0] d1 = '0;
    logic [DW-1:0] d2 = '0;
    logic          rdy1, rdy2, vo1, vo2, ov1, ov2, un1, un2;
    logic [DW-1:0] o1, o2;

    exp_t sb1[$];
    exp_t sb2[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cic_interp #(.DATA_WIDTH(16), .DATA_FRAC(15), .Q(1), .N(1)) u_q1 (
        .clk(clk), .rst_n(rst_n), .valid_in(v1), .ready_in(rdy1),
        .interp_factor(f1), .cic_in(d1), .cic_out(o1),
        .valid_out(vo1), .overflow(ov1), .underflow(un1)
    );

    cic_interp #(.DATA_WIDTH(16), .DATA_FRAC(15), .Q(2), .N(1)) u_q2 (
        .clk(clk), .rst_n(rst_n), .valid_in(v2), .ready_in(rdy2),
        .interp_factor(f2), .cic_in(d2), .cic_out(o2),
        .valid_out(vo2), .overflow(ov2), .underflow(un2)
    );

    // Output monitor for the Q=1 instance
    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (vo1) begin
            assert (sb1.size() > 0) else begin
                failures++;
                $error("FAIL q1_extra got=%h exp=none", o1);
            end
            if (sb1.size() > 0) begin
                e = sb1.pop_front();
                checks++;
                assert ({o1, ov1, un1} === e) else begin
                    failures++;
                    $error("FAIL q1_out got=%h ov=%b un=%b exp=%h ov=%b un=%b",
                           o1, ov1, un1, e.d, e.ov, e.un);
                end
            end
        end else begin
            assert ({ov1, un1} === 2'b00) else begin
                failures++;
                $error("FAIL q1_idle_flags got=%b%b exp=00", ov1, un1);
            end
        end
    end

    // Output monitor for the Q=2 instance
    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (vo2) begin
            assert (sb2.size() > 0) else begin
                failures++;
                $error("FAIL q2_extra got=%h exp=none", o2);
            end
            if (sb2.size() > 0) begin
                e = sb2.pop_front();
                checks++;
                assert ({o2, ov2, un2} === e) else begin
                    failures++;
                    $error("FAIL q2_out got=%h ov=%b un=%b exp=%h ov=%b un=%b",
                           o2, ov2, un2, e.d, e.ov, e.un);
                end
            end
        end else begin
            assert ({ov2, un2} === 2'b00) else begin
                failures++;
                $error("FAIL q2_idle_flags got=%b%b exp=00", ov2, un2);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input int sel, input logic [DW-1:0] d,
                        input logic ov, input logic un, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 1) sb1.push_back('{d, ov, un});
            else          sb2.push_back('{d, ov, un});
        end
    endtask

    task automatic send(input int sel, input logic [DW-1:0] d,
                        input logic [4:0] f, output int w);
        w = 0;
        if (sel == 1) begin v1 = 1'b1; d1 = d; f1 = f; end
        else          begin v2 = 1'b1; d2 = d; f2 = f; end
        while (((sel == 1) ? rdy1 : rdy2) !== 1'b1 && w < 64) begin
            @(negedge clk);
            w++;
        end
        check("send_wait_bound", 32'(w < 64), 32'd1);
        @(negedge clk);
        v1 = 1'b0;
        v2 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb1.size() + sb2.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (24) @(negedge clk);
        check("sb_empty", 32'(sb1.size() + sb2.size()), 32'd0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_q1", {o1, vo1, ov1, un1, rdy1}, {16'h0, 4'b0001});
        check("rst_q2", {o2, vo2, ov2, un2, rdy2}, {16'h0, 4'b0001});
        sb1.delete();
        sb2.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int acc;
        int vcnt;

        // Power-up reset
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("por_q1", {o1, vo1, ov1, un1, rdy1}, {16'h0, 4'b0001});
        check("por_q2", {o2, vo2, ov2, un2, rdy2}, {16'h0, 4'b0001});
        rst_n = 1'b1;
        @(negedge clk);

        // Q=1 R=4 single sample: flat 4-sample burst, 2-cycle latency
        push(1, 16'h4000, 1'b0, 1'b0, 4);
        send(1, 16'h4000, 5'd4, w);
        check("t1_vo_e0", vo1, 1'b0);
        @(negedge clk);
        check("t1_vo_e1", vo1, 1'b0);
        @(negedge clk);
        check("t1_vo_e2", vo1, 1'b1);
        drain();
        check("t1_hold", {o1, vo1}, {16'h4000, 1'b0});

        // Q=2 R=4 impulse then zeros, back-to-back
        push(2, 16'h1000, 1'b0, 1'b0, 1);
        push(2, 16'h2000, 1'b0, 1'b0, 1);
        push(2, 16'h3000, 1'b0, 1'b0, 1);
        push(2, 16'h4000, 1'b0, 1'b0, 1);
        push(2, 16'h3000, 1'b0, 1'b0, 1);
        push(2, 16'h2000, 1'b0, 1'b0, 1);
        push(2, 16'h1000, 1'b0, 1'b0, 1);
        push(2, 16'h0000, 1'b0, 1'b0, 5);
        send(2, 16'h4000, 5'd4, w);
        check("t2_rdy_low", rdy2, 1'b0);
        send(2, 16'h0000, 5'd4, w);
        check("t2_gap1", w, 3);
        send(2, 16'h0000, 5'd4, w);
        check("t2_gap2", w, 3);
        drain();

        // Q=2 R=2 full-scale positive, then R=1 exceeds range
        reset_dut();
        push(2, 16'h4000, 1'b0, 1'b0, 1);
        push(2, 16'h7FFF, 1'b0, 1'b0, 7);
        push(2, SAT ? 16'h7FFF : 16'hFFFE, SAT, 1'b0, 1);
        for (int i = 0; i < 4; i++) send(2, 16'h7FFF, 5'd2, w);
        send(2, 16'h7FFF, 5'd1, w);
        drain();

        // Q=2 R=2 full-scale negative, then R=1 below range
        reset_dut();
        push(2, 16'hC000, 1'b0, 1'b0, 1);
        push(2, 16'h8000, 1'b0, 1'b0, 7);
        push(2, SAT ? 16'h8000 : 16'h0000, 1'b0, SAT, 1);
        for (int i = 0; i < 4; i++) send(2, 16'h8000, 5'd2, w);
        send(2, 16'h8000, 5'd1, w);
        drain();

        // R=16 burst interrupted by reset at phase 5
        reset_dut();
        push(1, 16'h4000, 1'b0, 1'b0, 4);
        send(1, 16'h4000, 5'd16, w);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t4_async", {o1, vo1, ov1, un1, rdy1}, {16'h0, 4'b0001});
        check("t4_sb_done", 32'(sb1.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(1, 16'h4000, 1'b0, 1'b0, 16);
        send(1, 16'h4000, 5'd16, w);
        drain();

        // Illegal factor latched as 1; mid-burst factor change ignored
        reset_dut();
        push(1, 16'h1234, 1'b0, 1'b0, 1);
        send(1, 16'h1234, 5'd3, w);
        drain();
        push(1, 16'h0100, 1'b0, 1'b0, 4);
        send(1, 16'h0100, 5'd4, w);
        f1 = 5'd16;
        drain();
        check("t5_ready", rdy1, 1'b1);

        // valid_in held high with R=8: one accept per 8 clocks
        reset_dut();
        push(1, 16'h1000, 1'b0, 1'b0, 24);
        acc  = 0;
        vcnt = 0;
        v1 = 1'b1;
        d1 = 16'h1000;
        f1 = 5'd8;
        for (int c = 0; c < 24; c++) begin
            if (rdy1 === 1'b1) acc++;
            if (c >= 3 && vo1 === 1'b1) vcnt++;
            @(negedge clk);
        end
        v1 = 1'b0;
        check("t6_accepts", acc, 3);
        check("t6_vo_cont", vcnt, 21);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cic_interp.md
# cic_interp

Cascaded integrator-comb interpolator, the transmit-side counterpart of the CIC decimator in the DFE filter array. The block accepts 16-bit Q1.15 samples at the low rate. It runs a Q-stage comb chain once per accepted sample, zero-stuffs by a runtime factor of 1/2/4/8/16, and runs a Q-stage integrator chain at the 18 MHz clock. It rescales by the CIC gain, then rounds and saturates back to the input format.

## Interface
- DATA_WIDTH, 16, sample width
- DATA_FRAC, 15, fractional bits of input and output
- Q, 1, filter order (number of comb and integrator stages, ≥1)
- N, 1, differential delay (1 or 2)
- MAX_INTERP_FACTOR (localparam), 16
- ACC_WIDTH (localparam), DATA_WIDTH + Q·clog2(N·MAX_INTERP_FACTOR)
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_in  in  1  input sample strobe
- ready_in  out  1  block can accept a sample this cycle
- interp_factor  in  5  interpolation factor R
- cic_in  in  DATA_WIDTH  signed input sample
- cic_out  out  DATA_WIDTH  signed output sample (registered)
- valid_out  out  1  cic_out valid this cycle
- overflow  out  1  positive saturation on this output
- underflow  out  1  negative saturation on this output

## Operation
- Accept occurs when valid_in && ready_in. On accept:
  - latch R from interp_factor; values other than 1/2/4/8/16 are latched as 1;
  - compute the comb chain in one cycle, each stage y = x − x[n−N], with sign extension to ACC_WIDTH;
  - register the comb result as the stuff value and start a burst of R phases.
- Burst: a phase counter runs 0..R−1, advancing one per clock.
  - Integrator input is the stuff value at phase 0 and 0 at other phases.
  - The integrator chain is combinational-cascaded within a cycle: I1 += x, then Ik += I(k−1)_new.
  - Integrators are modulo-2^ACC_WIDTH (wrap) and update only in burst phases.
- ready_in = 1 when idle or at phase R−1. This allows back-to-back bursts with no gap and gives a throughput of one input per R clocks.
- Idle (no burst): integrators, comb delay lines and outputs hold. valid_out = 0.
- Scaling: arithmetic right shift of the final integrator by S = (Q−1)·log2(R) + Q·log2(N), using the latched R.
  - Rounding is half-up: add 2^(S−1) before the shift. There is no rounding when S = 0.
- Saturation (see Configuration): results above 2^(DATA_WIDTH−1)−1 clamp to 0x7FFF with overflow = 1. Results below −2^(DATA_WIDTH−1) clamp to 0x8000 with underflow = 1.
- R changes take effect only at accept; a mid-burst change on interp_factor is ignored.

## Timing
- Reset state: cic_out = 0, valid_out = 0, overflow = 0, underflow = 0, ready_in = 1. Counters, comb delays and integrators are all 0.
- Accept at edge E0: integrator phase 0 updates at E1. The first output is registered at E2, where valid_out rises. R outputs follow on consecutive cycles.
- overflow and underflow are registered alongside cic_out, are valid only while valid_out = 1, and are 0 otherwise.
- Reset asserted mid-burst: all state clears immediately and the burst is abandoned. After release, the first accept behaves as from power-up.
- valid_in held high while ready_in = 0: no accept, and the sample is not consumed.

## Configuration
- CIC_INTERP_SAT_EN defined: saturation and the overflow/underflow flags are active as above.
- CIC_INTERP_SAT_EN undefined: the rounded result is truncated to DATA_WIDTH LSBs (wraps), and overflow and underflow are tied to 0.

## Test plan
- Q=1, N=1, R=4; single input 0x4000, then idle → valid_out high for 4 cycles starting 2 cycles after accept, cic_out = 0x4000 ×4, then valid_out = 0 and cic_out holds.
- Q=2, N=1, R=4; impulse 0x4000 followed by zeros back-to-back → outputs 0x1000, 0x2000, 0x3000, 0x4000, 0x3000, 0x2000, 0x1000, 0x0000, with ready_in pulsing once per 4 cycles.
- Q=2, R=2; hold 0x7FFF for 4 accepts (outputs settle at 0x7FFF), then interp_factor = 1 → next output 0x7FFF with overflow = 1 (with macro); 0xFFFE with flags 0 (without macro).
- R=16 burst; assert rst_n low at phase 5 → all outputs 0 asynchronously and ready_in = 1 after release. Next impulse reproduces the power-up response.
- interp_factor = 3 at accept, Q=1, input 0x1234 → treated as R=1: single output 0x1234; changing interp_factor mid-burst has no effect on burst length.
- valid_in held high continuously, R=8 → exactly one accept per 8 cycles and valid_out continuously high once started.
